imem_loader: RTL and testbench

- Writer-side counterpart to the read-only instruction memory.
- Accepts a framed byte stream from the byte source (e.g. UART receiver) over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory write port.
- Holds the CPU in reset while a load is in progress.
- Sits between the byte source and the instruction memory write port; the fetch path is unaffected.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_loader_byte_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader state encoding and the default memory geometry.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          IMEM_MEM_SIZE   = 128;
    localparam int          IMEM_LEN_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Collects four bytes into a little-endian 32-bit word.
// The first byte of a word lands in bits [7:0].
module byte_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] byte_idx;

    assign word_ready = load && (byte_idx == 2'd3);

    // Shifting right places earlier bytes into lower lanes once all four have arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
        end else if (load) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= {byte_data, word[31:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction memory write port,
// holding the CPU in reset while the load runs.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE  = IMEM_MEM_SIZE,
    parameter int LEN_WIDTH = IMEM_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [31:0]          wr_data,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_loaded
);

    loader_state_t state_q, state_d;

    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] word_idx;
    logic [LEN_WIDTH-1:0] word_idx_next;
    logic [15:0]          len_full;
    logic [31:0]          live_addr;
    logic [31:0]          addr_hold;
    logic [31:0]          data_hold;
    logic [31:0]          asm_word;
    logic                 asm_ready;
    logic                 asm_clear;
    logic                 accept;
    logic                 in_range;
    logic                 start_load;

    assign in_ready      = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign busy          = in_ready || (state_q == WRITE);
    assign cpu_hold      = busy;
    assign accept        = in_valid && in_ready && !abort;
    assign start_load    = (state_q == IDLE) && start && !abort;
    assign len_full      = {in_data, len[7:0]};
    assign word_idx_next = word_idx + LEN_WIDTH'(1);
    assign live_addr     = 32'(word_idx) << 2;
    assign in_range      = 32'(word_idx) < 32'(MEM_SIZE);
    assign asm_clear     = (state_q != DATA) && (state_q != WRITE);

    // Write outputs are live during WRITE and otherwise replay the last written word.
    assign wr_en   = (state_q == WRITE) && in_range;
    assign wr_addr = wr_en ? live_addr : addr_hold;
    assign wr_data = wr_en ? asm_word  : data_hold;

    byte_word_assembler u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .load       (accept && (state_q == DATA)),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_load) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (abort)       state_d = IDLE;
                else if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (abort)       state_d = IDLE;
                else if (accept) state_d = (len_full == 16'd0) ? DONE : DATA;
            end
            DATA: begin
                if (abort)          state_d = IDLE;
                else if (asm_ready) state_d = WRITE;
            end
            WRITE: begin
                if (abort)                     state_d = IDLE;
                else if (word_idx_next == len) state_d = DONE;
                else                           state_d = DATA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Length, word counter, status flags and the held write-port values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len          <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            addr_hold    <= 32'd0;
            data_hold    <= 32'd0;
        end else begin
            if (start_load) begin
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
            end
            if (state_q == LEN_LO && accept) begin
                len <= LEN_WIDTH'(in_data);
            end
            if (state_q == LEN_HI && accept) begin
                len      <= LEN_WIDTH'(len_full);
                word_idx <= '0;
            end
            if (state_q == WRITE) begin
                word_idx <= word_idx_next;
                if (in_range) begin
                    words_loaded <= words_loaded + LEN_WIDTH'(1);
                    addr_hold    <= live_addr;
                    data_hold    <= asm_word;
                end else begin
                    error <= 1'b1;
                end
            end
            if (busy && abort) begin
                error <= 1'b1;
            end
            if (state_d == DONE && state_q != DONE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames
// compared against a simple frame-level model of the expected memory writes.
module tb_imem_loader;

    localparam int TB_MEM_SIZE = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks;
    int failures;

    logic [63:0] write_log[$];
    logic [31:0] words[$];
    int          ready_in_write;

    imem_loader #(.MEM_SIZE(TB_MEM_SIZE), .LEN_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write is captured once, mid-cycle, along with any in_ready seen alongside it.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            write_log.push_back({wr_addr, wr_data});
            if (in_ready !== 1'b0) ready_in_write++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulse(input bit is_abort);
        @(negedge clk);
        if (is_abort) abort = 1'b1; else start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall, output bit ok);
        ok = 1'b0;
        for (int budget = 0; budget < 200; budget++) begin
            @(negedge clk);
            in_data  = b;
            in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Sends a full frame of len words; random words unless words[] is already filled.
    task automatic applyStimulus(input int len, input bit stall, input bit poke_start);
        bit ok;
        bit all_ok = 1'b1;
        if (words.size() == 0) begin
            for (int i = 0; i < len; i++) words.push_back($urandom());
        end
        write_log.delete();
        ready_in_write = 0;
        pulse(1'b0);
        send_byte(8'(len), stall, ok);       all_ok &= ok;
        send_byte(8'(len >> 8), stall, ok);  all_ok &= ok;
        for (int w = 0; w < len; w++) begin
            if (poke_start && w == 1) pulse(1'b0);
            for (int b = 0; b < 4; b++) begin
                send_byte(words[w][8*b +: 8], stall, ok);
                all_ok &= ok;
            end
        end
        checkOutput("bytes_consumed", {31'd0, all_ok}, 32'd1);
        wait_idle();
    endtask

    // Expected result of a complete frame: only the first TB_MEM_SIZE words reach memory.
    task automatic verify_load(input string tag, input int len);
        int n_exp = (len < TB_MEM_SIZE) ? len : TB_MEM_SIZE;
        checkOutput({tag, "_write_count"}, write_log.size(), n_exp);
        for (int i = 0; i < n_exp && i < write_log.size(); i++) begin
            checkOutput({tag, "_addr"}, write_log[i][63:32], 32'(i * 4));
            checkOutput({tag, "_data"}, write_log[i][31:0], words[i]);
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_error"}, {31'd0, error}, (len > TB_MEM_SIZE) ? 32'd1 : 32'd0);
        checkOutput({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'(n_exp));
        checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        checkOutput({tag, "_ready_in_write"}, ready_in_write, 32'd0);
        words.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 32'd0);
        checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
        checkOutput({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        bit ok;
        int rlen;
        checks = 0;
        failures = 0;
        ready_in_write = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic two-word program
        words.push_back(32'h00A00513);
        words.push_back(32'h00B00593);
        applyStimulus(2, 1'b0, 1'b0);
        verify_load("basic", 2);

        // Zero length frame
        write_log.delete();
        pulse(1'b0);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        checkOutput("zero_writes", write_log.size(), 32'd0);
        checkOutput("zero_error", {31'd0, error}, 32'd0);

        // Overflow past the memory depth
        applyStimulus(6, 1'b0, 1'b0);
        verify_load("overflow", 6);

        // Same basic program under random backpressure, with a stray start mid-load
        words.push_back(32'h00A00513);
        words.push_back(32'h00B00593);
        applyStimulus(2, 1'b1, 1'b1);
        verify_load("stall", 2);

        for (int t = 0; t < 6; t++) begin
            rlen = $urandom_range(1, 6);
            applyStimulus(rlen, ($urandom_range(0, 1) == 1), 1'b0);
            verify_load("random", rlen);
        end

        // Abort after two bytes of word 1
        write_log.delete();
        words.push_back($urandom());
        pulse(1'b0);
        send_byte(8'd3, 1'b0, ok);
        send_byte(8'd0, 1'b0, ok);
        for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8], 1'b0, ok);
        send_byte(8'hAA, 1'b0, ok);
        send_byte(8'h55, 1'b0, ok);
        pulse(1'b1);
        repeat (4) @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_error", {31'd0, error}, 32'd1);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_writes", write_log.size(), 32'd1);
        checkOutput("abort_words_loaded", {16'd0, words_loaded}, 32'd1);
        words.delete();
        applyStimulus(3, 1'b1, 1'b0);
        verify_load("after_abort", 3);

        // Abort together with start in IDLE: no load begins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", {31'd0, busy}, 32'd0);

        // Async reset in the middle of a word
        write_log.delete();
        pulse(1'b0);
        send_byte(8'd2, 1'b0, ok);
        send_byte(8'd0, 1'b0, ok);
        send_byte(8'h11, 1'b0, ok);
        send_byte(8'h22, 1'b0, ok);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        write_log.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'($urandom());
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("post_reset_writes", write_log.size(), 32'd0);
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
